// File: rtl/pipe_perf_monitor_if.sv
// Bus bundle for pipe_perf_monitor: run control, event strobes and the indexed read port.
// The snapshot signals exist only when PERF_SNAPSHOT_EN is defined.
interface pipe_perf_monitor_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int SEL_W  = 4
);
    logic              start_i;
    logic              freeze_i;
    logic              clear_i;
    logic [CNT_W-1:0]  limit_i;
    logic [NUM_CH-1:0] event_i;
    logic [SEL_W-1:0]  sel_i;
    logic [CNT_W-1:0]  rd_data_o;
    logic [CNT_W-1:0]  cycle_o;
    logic [NUM_CH-1:0] overflow_o;
    logic              running_o;
    logic              done_o;
`ifdef PERF_SNAPSHOT_EN
    logic              snap_i;
    logic              rd_shadow_i;
`endif

    modport master (
        output start_i, freeze_i, clear_i, limit_i, event_i, sel_i,
`ifdef PERF_SNAPSHOT_EN
        output snap_i, rd_shadow_i,
`endif
        input  rd_data_o, cycle_o, overflow_o, running_o, done_o
    );

    modport slave (
        input  start_i, freeze_i, clear_i, limit_i, event_i, sel_i,
`ifdef PERF_SNAPSHOT_EN
        input  snap_i, rd_shadow_i,
`endif
        output rd_data_o, cycle_o, overflow_o, running_o, done_o
    );
endinterface

// File: rtl/pipe_perf_monitor.sv
// Pipeline performance counter bank: NUM_CH saturating event counters plus a run-cycle counter
// with a self-stop limit. Define PERF_SNAPSHOT_EN to add a shadow copy readable via rd_shadow_i.
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | stopped, counters hold, waiting for start_i
// ST_RUN    | counting cycles and events every edge
// ST_FROZEN | paused by freeze_i, all state held
// ST_DONE   | cycle limit reached, held until clear_i/rst_i
module pipe_perf_monitor #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int SEL_W  = 4
) (
    input logic             clk_i,
    input logic             rst_i,
    pipe_perf_monitor_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state_q, state_d;
    logic              count_en;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [CNT_W-1:0]  cycle_q, cycle_d, cycle_inc;
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic [CNT_W-1:0]  rd_live;

    // Wrapping increment: a saturated cycle counter yields 0 here, so it can never hit a nonzero limit.
    assign cycle_inc = cycle_q + CNT_W'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_en = 1'b0;
        if (bus.clear_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start_i) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (!bus.start_i) begin
                        state_d = ST_IDLE;
                    end else if (bus.freeze_i) begin
                        state_d = ST_FROZEN;
                    end else begin
                        count_en = 1'b1;
                        if (bus.limit_i != '0 && cycle_inc == bus.limit_i) state_d = ST_DONE;
                    end
                end
                ST_FROZEN: begin
                    if (!bus.start_i)      state_d = ST_IDLE;
                    else if (!bus.freeze_i) state_d = ST_RUN;
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cycle_d = cycle_q;
        ovf_d   = ovf_q;
        for (int k = 0; k < NUM_CH; k++) cnt_d[k] = cnt_q[k];
        if (bus.clear_i) begin
            cycle_d = '0;
            ovf_d   = '0;
            for (int k = 0; k < NUM_CH; k++) cnt_d[k] = '0;
        end else if (count_en) begin
            if (cycle_q != CNT_MAX) cycle_d = cycle_inc;
            for (int k = 0; k < NUM_CH; k++) begin
                if (bus.event_i[k]) begin
                    if (cnt_q[k] == CNT_MAX) ovf_d[k] = 1'b1;
                    else                     cnt_d[k] = cnt_q[k] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_q <= '0;
            ovf_q   <= '0;
            for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
        end else begin
            cycle_q <= cycle_d;
            ovf_q   <= ovf_d;
            for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= cnt_d[k];
        end
    end

    assign bus.overflow_o = ovf_q;
    assign bus.running_o  = (state_q == ST_RUN);
    assign bus.done_o     = (state_q == ST_DONE);

`ifdef PERF_SNAPSHOT_EN
    logic [CNT_W-1:0] shd_cnt_q [NUM_CH];
    logic [CNT_W-1:0] shd_cycle_q;
    logic [CNT_W-1:0] rd_shd;

    // The shadow captures this edge's post-update values so a snapshot matches what live reads show next.
    always_ff @(posedge clk_i) begin
        if (rst_i || bus.clear_i) begin
            shd_cycle_q <= '0;
            for (int k = 0; k < NUM_CH; k++) shd_cnt_q[k] <= '0;
        end else if (bus.snap_i) begin
            shd_cycle_q <= cycle_d;
            for (int k = 0; k < NUM_CH; k++) shd_cnt_q[k] <= cnt_d[k];
        end
    end

    always_comb begin
        rd_live = '0;
        rd_shd  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (bus.sel_i == SEL_W'(k)) begin
                rd_live = cnt_q[k];
                rd_shd  = shd_cnt_q[k];
            end
        end
    end

    assign bus.rd_data_o = bus.rd_shadow_i ? rd_shd : rd_live;
    assign bus.cycle_o   = bus.rd_shadow_i ? shd_cycle_q : cycle_q;
`else
    always_comb begin
        rd_live = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (bus.sel_i == SEL_W'(k)) rd_live = cnt_q[k];
        end
    end

    assign bus.rd_data_o = rd_live;
    assign bus.cycle_o   = cycle_q;
`endif
endmodule

// File: doc/pipe_perf_monitor.md
Name: pipe_perf_monitor

Overview:
- Parametrised pipeline performance counter bank; successor to the fixed stall/flush tallies the CPU bench keeps.
- Instantiated beside the CPU; counts NUM_CH single-bit event lines (stall, flush, retire, load-use, ...) plus elapsed run cycles.
- Stops itself at a programmable cycle limit.
- Results are read through an indexed read port, so benches and debug logic use one interface regardless of channel count.

Parameters:
- NUM_CH, 4, number of event channels (1..16)
- CNT_W, 32, width of each event counter and of the cycle counter (8..64)
- SEL_W, 4, width of the channel select; must satisfy 2^SEL_W >= NUM_CH

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  level; run enable, mirrors CPU start
- freeze_i  in  1  level; pause counting without losing state
- clear_i  in  1  pulse; zero all counters and return to IDLE
- limit_i  in  CNT_W  cycle limit; 0 = unlimited
- event_i  in  NUM_CH  per-channel event strobes, sampled each edge
- sel_i  in  SEL_W  read-port channel select
- rd_data_o  out  CNT_W  count of channel sel_i; combinational from registers
- cycle_o  out  CNT_W  run-cycle counter
- overflow_o  out  NUM_CH  sticky per-channel saturation flags
- running_o  out  1  high in RUN
- done_o  out  1  high in DONE

Behaviour:
- Reset value: rst_i=1 at an edge sets state=IDLE and zeroes all counters, cycle_o, overflow_o, running_o and done_o.
- rd_data_o=0 after reset.
- States: IDLE, RUN, FROZEN, DONE; 2-bit encoded register.
- Priority at each edge: rst_i > clear_i > DONE hold > start_i low > freeze_i > limit hit > normal count.
- IDLE: counters hold. start_i=1 -> RUN. Events at that edge are not counted.
- RUN, normal edge:
  - cycle counter +1.
  - for each k with event_i[k]=1, cnt[k] +1.
  - counting occurs only at edges where the registered state is RUN.
- RUN transitions:
  - start_i=0 -> IDLE; counts held; no count at that edge.
  - freeze_i=1 -> FROZEN; no count at that edge.
  - limit_i!=0 and cycle_o+1 == limit_i -> DONE; this edge's events and cycle are still counted, so cycle_o ends equal to limit_i.
  - limit_i <= cycle_o while in RUN: no match is possible, counting continues until saturation.
- FROZEN: everything holds.
  - freeze_i=0 with start_i=1 -> RUN.
  - start_i=0 -> IDLE.
- DONE: everything holds, done_o=1. Only clear_i or rst_i leave DONE; start_i and freeze_i are ignored.
- clear_i (any state): zero all counters, cycle and overflow_o; next state IDLE.
  - If start_i is still high, the state is RUN one edge later.
- Saturation: a counter at all-ones with an increment request stays at all-ones and sets its overflow_o bit.
  - The cycle counter also saturates; it has no flag.
  - Overflow bits are sticky until clear_i or rst_i.
- Read port: rd_data_o = cnt[sel_i] when sel_i < NUM_CH, else 0.
  - Read latency: an event sampled at edge N is visible on rd_data_o after edge N.
- running_o and done_o are decoded from the state register.
- Simultaneous events on all channels count independently in the same edge.

Optional Feature:
- Macro: PERF_SNAPSHOT_EN.
- Defined:
  - Adds input snap_i (1) and input rd_shadow_i (1), plus a shadow copy of all counters and the cycle counter.
  - snap_i=1 at an edge copies the post-update values of that edge into the shadow; this works in every state and is suppressed by rst_i/clear_i, which also zero the shadow.
  - rd_shadow_i=1 makes rd_data_o and cycle_o read the shadow instead of the live counters.
- Undefined: no snap_i or rd_shadow_i ports, no shadow storage; outputs always read the live counters.

Test Plan:
- Reset: rst_i=1 for 2 edges with random event_i -> all outputs 0, running_o=0, done_o=0.
- Basic count (NUM_CH=4, CNT_W=32), start_i=1, limit_i=0, event_i=4'b0101 for 10 run edges -> ch0=10, ch1=0, ch2=10, ch3=0, cycle_o=10; sel_i=7 -> rd_data_o=0.
- Limit: limit_i=5, event_i=4'b1111 continuous -> done_o after 5th run edge; all channels=5, cycle_o=5; values unchanged 20 edges later; clear_i -> zeros, IDLE, then RUN next edge since start_i=1.
- Saturation (CNT_W=8): 300 edges with event_i[1]=1 -> ch1=255, overflow_o=4'b0010, cycle_o=255; overflow_o persists until clear_i.
- Freeze/priority: in RUN assert freeze_i for 3 edges with events on -> counts and cycle frozen, resume +1 per edge after release; freeze_i=1 with clear_i=1 same edge -> cleared to IDLE; start_i dropped mid-run -> IDLE with counts held.
- PERF_SNAPSHOT_EN: snap_i at cycle 6 of an all-ones run -> with rd_shadow_i=1 rd_data_o=6 for every channel and cycle_o=6, while live counters keep advancing.
